// File: rtl/gcd_pkg.sv
// Shared constants for the GCD/LCM engine: FSM state encoding and
// the width helper for the Stein common-power-of-two counter.
package gcd_pkg;

  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] S_IDLE  = 3'd0;
  localparam logic [ST_W-1:0] S_PAIR  = 3'd1;
  localparam logic [ST_W-1:0] S_STEIN = 3'd2;
  localparam logic [ST_W-1:0] S_DIV   = 3'd3;
  localparam logic [ST_W-1:0] S_DONE  = 3'd4;

  function automatic int k_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/gcd_lcm_engine_if.sv
// Request/result handshake bundle of the GCD/LCM engine.
// master: requester side; slave: engine side.
interface gcd_lcm_engine_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 lcm_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     gcd;
  logic [2*WIDTH-1:0]   lcm;
  logic [CNT_W-1:0]     cycles;

  modport master (
    output in_valid, a, b, lcm_en, out_ready,
    input  in_ready, out_valid, gcd, lcm, cycles
  );

  modport slave (
    input  in_valid, a, b, lcm_en, out_ready,
    output in_ready, out_valid, gcd, lcm, cycles
  );

endinterface

// File: rtl/gcd_div_unit.sv
// Restoring shift-subtract divider, WIDTH iterations per divide.
// Ports: start/dividend/divisor in; done pulse and quotient out.
module gcd_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dsr;
  logic [CW-1:0]    left;
  logic [WIDTH:0]   trial;

  // quotient doubles as the dividend shift register
  assign trial = {rem, quotient[WIDTH-1]} - {1'b0, dsr};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem      <= '0;
      dsr      <= '0;
      left     <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= '0;
        dsr      <= divisor;
        quotient <= dividend;
        left     <= CW'(WIDTH);
      end else if (left != '0) begin
        left <= left - CW'(1);
        done <= (left == CW'(1));
        if (!trial[WIDTH]) begin
          rem      <= trial[WIDTH-1:0];
          quotient <= {quotient[WIDTH-2:0], 1'b1};
        end else begin
          rem      <= {rem[WIDTH-2:0], quotient[WIDTH-1]};
          quotient <= {quotient[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/gcd_lcm_engine.sv
// Multi-cycle binary-GCD engine with optional LCM via sequential divide.
// Ports: clk, rst_n (sync, active-low), bus (slave handshake bundle).
import gcd_pkg::*;

module gcd_lcm_engine #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  gcd_lcm_engine_if.slave bus
);

  localparam int KW = k_width(WIDTH);
  localparam int LW = 2 * WIDTH;

  logic [ST_W-1:0]  state;
  logic [WIDTH-1:0] u;
  logic [WIDTH-1:0] v;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [KW-1:0]    k;
  logic             en_l;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] gcd_r;
  logic [LW-1:0]    lcm_r;

  logic             uv_zero;
  logic [WIDTH-1:0] g_nxt;
  logic             busy;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] quo;

  assign uv_zero = (u == '0) || (v == '0);
  assign g_nxt   = (u | v) << k;
  assign busy    = (state == S_PAIR) ||
                   (state == S_STEIN) ||
                   (state == S_DIV);

  // divider launches on the same edge that leaves STEIN
  assign div_start = (state == S_STEIN) && uv_zero && en_l;

  gcd_div_unit #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (a_l),
    .divisor  (g_nxt),
    .done     (div_done),
    .quotient (quo)
  );

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.gcd       = gcd_r;
  assign bus.lcm       = lcm_r;
  assign bus.cycles    = cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      u     <= '0;
      v     <= '0;
      a_l   <= '0;
      b_l   <= '0;
      k     <= '0;
      en_l  <= 1'b0;
      cnt   <= '0;
      gcd_r <= '0;
      lcm_r <= '0;
    end else begin
      if (busy && cnt != {CNT_W{1'b1}})
        cnt <= cnt + CNT_W'(1);
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            u    <= bus.a;
            v    <= bus.b;
            a_l  <= bus.a;
            b_l  <= bus.b;
            k    <= '0;
            en_l <= bus.lcm_en;
            cnt  <= '0;
            if (bus.a == '0 || bus.b == '0) begin
              gcd_r <= bus.a | bus.b;
              lcm_r <= '0;
              state <= S_DONE;
            end else begin
              state <= S_PAIR;
            end
          end
        end
        S_PAIR: begin
          if (!u[0] && !v[0]) begin
            u <= u >> 1;
            v <= v >> 1;
            k <= k + KW'(1);
          end else begin
            state <= S_STEIN;
          end
        end
        S_STEIN: begin
          if (uv_zero) begin
            gcd_r <= g_nxt;
            lcm_r <= '0;
            state <= en_l ? S_DIV : S_DONE;
          end else if (!u[0]) begin
            u <= u >> 1;
          end else if (!v[0]) begin
            v <= v >> 1;
          end else if (u >= v) begin
            u <= (u - v) >> 1;
          end else begin
            v <= (v - u) >> 1;
          end
        end
        S_DIV: begin
          if (div_done) begin
            lcm_r <= LW'(quo) * LW'(b_l);
            state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_lcm_engine.sv
// Testbench for gcd_lcm_engine: directed cases plus random sweep at
// WIDTH=16 and WIDTH=8 against a Euclid-based reference model.
module tb_gcd_lcm_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gcd_lcm_engine_if #(.WIDTH(16), .CNT_W(8)) i16 ();
  gcd_lcm_engine_if #(.WIDTH(8),  .CNT_W(8)) i8  ();

  gcd_lcm_engine #(.WIDTH(16), .CNT_W(8)) u16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i16)
  );

  gcd_lcm_engine #(.WIDTH(8), .CNT_W(8)) u8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (i8)
  );

  int checks = 0;
  int failures = 0;
  bit cur = 1'b0;

  wire        s_rdy = cur ? i8.in_ready  : i16.in_ready;
  wire        s_ov  = cur ? i8.out_valid : i16.out_valid;
  wire [63:0] s_gcd = cur ? 64'(i8.gcd)    : 64'(i16.gcd);
  wire [63:0] s_lcm = cur ? 64'(i8.lcm)    : 64'(i16.lcm);
  wire [63:0] s_cyc = cur ? 64'(i8.cycles) : 64'(i16.cycles);

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_gcd(input logic [63:0] x,
                                          input logic [63:0] y);
    logic [63:0] p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  function automatic logic [63:0] ref_lcm(input logic [63:0] x,
                                          input logic [63:0] y,
                                          input bit en);
    if (!en || x == 0 || y == 0) return 64'd0;
    return (x / ref_gcd(x, y)) * y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit vld, input logic [15:0] a,
                     input logic [15:0] b, input bit en);
    if (cur) begin
      i8.in_valid = vld;
      i8.a        = a[7:0];
      i8.b        = b[7:0];
      i8.lcm_en   = en;
    end else begin
      i16.in_valid = vld;
      i16.a        = a;
      i16.b        = b;
      i16.lcm_en   = en;
    end
  endtask

  task automatic rdy(input bit r);
    if (cur) i8.out_ready = r;
    else     i16.out_ready = r;
  endtask

  task automatic job(input bit sel, input logic [15:0] a,
                     input logic [15:0] b, input bit en,
                     input int hold);
    logic [15:0] am, bm;
    logic [63:0] gs, ls, cs;
    int w, n;
    cur = sel;
    w  = sel ? 8 : 16;
    am = sel ? {8'h00, a[7:0]} : a;
    bm = sel ? {8'h00, b[7:0]} : b;
    #0;
    n = 0;
    while (!s_rdy && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 64'(s_rdy), 64'd1);
    rdy(hold == 0);
    drv(1'b1, am, bm, en);
    tick();
    drv(1'b0, 16'($urandom), 16'($urandom), ~en);
    n = 0;
    while (!s_ov && n < 200) begin
      tick();
      n++;
    end
    chk("done_seen", 64'(s_ov), 64'd1);
    chk("gcd", s_gcd, ref_gcd(64'(am), 64'(bm)));
    chk("lcm", s_lcm, ref_lcm(64'(am), 64'(bm), en));
    chk("cyc_bound", 64'(s_cyc <= 64'(3 * w + 4)), 64'd1);
    if (am == 0 || bm == 0)
      chk("cyc_zero", s_cyc, 64'd0);
    if (hold > 0) begin
      gs = s_gcd;
      ls = s_lcm;
      cs = s_cyc;
      for (int i = 0; i < hold; i++) begin
        drv(1'b1, 16'($urandom), 16'($urandom), 1'b1);
        tick();
        chk("hold_ov", 64'(s_ov), 64'd1);
        chk("hold_rdy", 64'(s_rdy), 64'd0);
        chk("hold_gcd", s_gcd, gs);
        chk("hold_lcm", s_lcm, ls);
        chk("hold_cyc", s_cyc, cs);
      end
      drv(1'b0, 16'd0, 16'd0, 1'b0);
      rdy(1'b1);
    end
    tick();
    chk("ov_drop", 64'(s_ov), 64'd0);
    chk("idle_rdy", 64'(s_rdy), 64'd1);
  endtask

  task automatic chk_reset(input bit sel);
    cur = sel;
    #0;
    chk("rst_rdy", 64'(s_rdy), 64'd1);
    chk("rst_ov", 64'(s_ov), 64'd0);
    chk("rst_gcd", s_gcd, 64'd0);
    chk("rst_lcm", s_lcm, 64'd0);
    chk("rst_cyc", s_cyc, 64'd0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    int r, sh;
    i16.in_valid = 0; i16.a = 0; i16.b = 0;
    i16.lcm_en = 0;   i16.out_ready = 0;
    i8.in_valid = 0;  i8.a = 0;  i8.b = 0;
    i8.lcm_en = 0;    i8.out_ready = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk_reset(1'b0);
    chk_reset(1'b1);
    rst_n = 1'b1;
    tick();

    job(1'b0, 16'd48, 16'd18, 1'b1, 10);
    job(1'b0, 16'd1024, 16'd96, 1'b1, 0);
    job(1'b0, 16'd0, 16'd35, 1'b1, 0);
    job(1'b0, 16'd0, 16'd0, 1'b1, 0);
    job(1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 0);
    job(1'b0, 16'd65521, 16'd65519, 1'b1, 0);
    job(1'b0, 16'd48, 16'd18, 1'b0, 0);
    job(1'b1, 16'h00FF, 16'h00FF, 1'b1, 2);
    job(1'b1, 16'd12, 16'd0, 1'b1, 0);

    // reset while the 16-bit engine is deep in Stein reduction
    cur = 1'b0;
    drv(1'b1, 16'd65521, 16'd65519, 1'b1);
    tick();
    drv(1'b0, 16'd0, 16'd0, 1'b0);
    repeat (6) tick();
    chk("mid_busy", 64'(s_rdy), 64'd0);
    rst_n = 1'b0;
    tick();
    chk_reset(1'b0);
    rst_n = 1'b1;
    job(1'b0, 16'd48, 16'd18, 1'b1, 0);

    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 40; j++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        r  = $urandom_range(0, 9);
        if (r == 0) ra = 16'd0;
        if (r == 1) rb = 16'd0;
        if (r == 2) begin
          sh = $urandom_range(1, 5);
          ra = ra << sh;
          rb = rb << sh;
        end
        if (r == 3) rb = ra;
        job(s[0], ra, rb, ($urandom_range(0, 3) != 0),
            (r == 4) ? 3 : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
